// File: rtl/cpu_pkg.sv
// Shared CPU definitions: requester indices, datapath widths, the R0 reset value and the writeback request payload.
package cpu_pkg;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned NREGS = 1 << AW;

  localparam int unsigned REQ_ALU    = 0;
  localparam int unsigned REQ_MEM    = 1;
  localparam int unsigned REQ_MULDIV = 2;

  localparam logic [AW-1:0] R0_IDX   = AW'(0);
  localparam logic [DW-1:0] R0_RESET = 16'h0000;

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    logic          r0_en;
    logic [DW-1:0] r0_data;
  } wb_req_t;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [AW-1:0] idx);
    return NREGS'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter: one-hot grant searched from ptr upward,
// ptr moves past the winner whenever the grant is taken.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] win_idx;
  logic          found;
  logic [PW-1:0] idx_v;
  int unsigned   sum_v;

  always_comb begin
    grant   = '0;
    win_idx = ptr_q;
    found   = 1'b0;
    idx_v   = '0;
    sum_v   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      sum_v = 32'(ptr_q) + k;
      if (sum_v >= N) sum_v = sum_v - N;
      idx_v = PW'(sum_v);
      if (!found && req[idx_v]) begin
        grant[idx_v] = 1'b1;
        win_idx      = idx_v;
        found        = 1'b1;
      end
    end
  end

  // Pointer lands just after the winner so it has lowest priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      if (win_idx == PW'(N - 1)) ptr_d = '0;
      else                       ptr_d = win_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regwrite_arbiter.sv
// Arbitrates ALU / MEM / MULDIV writebacks onto the register file's single write port
// and keeps an R0 shadow so every strobe carries the correct R0 value.
module regwrite_arbiter
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_dest,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_r0_en,
  input  logic [NREQ*DW-1:0]   req_r0_data,
  output logic                 rf_write,
  output logic [AW-1:0]        rf_dest,
  output logic [DW-1:0]        rf_data,
  output logic [DW-1:0]        rf_r0_data,
  output logic [NREGS-1:0]     pending_mask,
  output logic                 rf_rst_n
);

  wb_req_t         req_s [NREQ];
  wb_req_t         sel;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] grant;
  logic            transfer;
  logic [DW-1:0]   r0_resolved;

  logic            rf_write_q, rf_write_d;
  logic [AW-1:0]   rf_dest_q, rf_dest_d;
  logic [DW-1:0]   rf_data_q, rf_data_d;
  logic [DW-1:0]   r0_shadow_q, r0_shadow_d;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_s[i].dest    = req_dest[i*AW +: AW];
      req_s[i].data    = req_data[i*DW +: DW];
      req_s[i].r0_en   = req_r0_en[i];
      req_s[i].r0_data = req_r0_data[i*DW +: DW];
    end
  end

  // Nothing is granted while reset is held, even though requesters stay valid.
  assign arb_req  = req_valid & {NREQ{~reset}};
  assign transfer = |grant;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (transfer),
    .grant   (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) sel = req_s[i];
    end
  end

  // R0 side-write beats the destination write; otherwise R0 is rewritten with itself.
  always_comb begin
    if (sel.r0_en)                r0_resolved = sel.r0_data;
    else if (sel.dest == R0_IDX)  r0_resolved = sel.data;
    else                          r0_resolved = r0_shadow_q;
  end

  always_comb begin
    rf_write_d  = transfer;
    rf_dest_d   = rf_dest_q;
    rf_data_d   = rf_data_q;
    r0_shadow_d = r0_shadow_q;
    if (transfer) begin
      rf_dest_d   = sel.dest;
      rf_data_d   = sel.data;
      r0_shadow_d = r0_resolved;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write_q  <= 1'b0;
      rf_dest_q   <= '0;
      rf_data_q   <= '0;
      r0_shadow_q <= R0_RESET;
    end else begin
      rf_write_q  <= rf_write_d;
      rf_dest_q   <= rf_dest_d;
      rf_data_q   <= rf_data_d;
      r0_shadow_q <= r0_shadow_d;
    end
  end

  // The shadow only changes on an issued write, so it is also the held R0 output.
  assign rf_write   = rf_write_q;
  assign rf_dest    = rf_dest_q;
  assign rf_data    = rf_data_q;
  assign rf_r0_data = r0_shadow_q;
  assign rf_rst_n   = ~reset;

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        pending_mask = pending_mask | reg_onehot(req_s[i].dest);
        if (req_s[i].r0_en) pending_mask = pending_mask | reg_onehot(R0_IDX);
      end
    end
    if (rf_write_q) begin
      pending_mask = pending_mask | reg_onehot(rf_dest_q) | reg_onehot(R0_IDX);
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter with a cycle-level reference model and hand-pinned expectations.
module tb_regwrite_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [11:0] req_dest;
  logic [47:0] req_data;
  logic [2:0]  req_r0_en;
  logic [47:0] req_r0_data;
  logic        rf_write;
  logic [3:0]  rf_dest;
  logic [15:0] rf_data;
  logic [15:0] rf_r0_data;
  logic [15:0] pending_mask;
  logic        rf_rst_n;

  int checks = 0;
  int errors = 0;
  bit done = 0;
  int glog[$];

  regwrite_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dest     (req_dest),
    .req_data     (req_data),
    .req_r0_en    (req_r0_en),
    .req_r0_data  (req_r0_data),
    .rf_write     (rf_write),
    .rf_dest      (rf_dest),
    .rf_data      (rf_data),
    .rf_r0_data   (rf_r0_data),
    .pending_mask (pending_mask),
    .rf_rst_n     (rf_rst_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] d, input logic [15:0] dat,
                         input logic en, input logic [15:0] r0d);
    req_valid[i]          = v;
    req_dest[i*4 +: 4]    = d;
    req_data[i*16 +: 16]  = dat;
    req_r0_en[i]          = en;
    req_r0_data[i*16 +: 16] = r0d;
  endtask

  task automatic clr_all();
    req_valid = '0;
    req_r0_en = '0;
  endtask

  // Reference model: arbitration order, issued write and R0 contents from the rules.
  initial begin : model
    int          m_ptr;
    logic        m_wr;
    logic [3:0]  m_dest;
    logic [15:0] m_data;
    logic [15:0] m_r0;
    int          eg;
    int          idx;
    logic [2:0]  er;
    logic [15:0] ep;
    m_ptr = 0; m_wr = 0; m_dest = 0; m_data = 0; m_r0 = 0;
    while (!done) begin
      @(negedge clk);
      if (reset) begin
        m_ptr = 0; m_wr = 0; m_dest = 0; m_data = 0; m_r0 = 0;
      end
      eg = -1;
      if (!reset) begin
        for (int k = 0; k < 3; k++) begin
          idx = (m_ptr + k) % 3;
          if (eg < 0 && req_valid[idx]) eg = idx;
        end
      end
      er = (eg >= 0) ? 3'(1 << eg) : 3'b000;
      ep = '0;
      for (int j = 0; j < 3; j++) begin
        if (req_valid[j]) begin
          ep = ep | (16'(1) << req_dest[j*4 +: 4]);
          if (req_r0_en[j]) ep[0] = 1'b1;
        end
      end
      if (m_wr) begin
        ep = ep | (16'(1) << m_dest);
        ep[0] = 1'b1;
      end
      check("ready", 32'(req_ready), 32'(er));
      check("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
      check("rf_write", 32'(rf_write), 32'(m_wr));
      check("rf_dest", 32'(rf_dest), 32'(m_dest));
      check("rf_data", 32'(rf_data), 32'(m_data));
      check("rf_r0_data", 32'(rf_r0_data), 32'(m_r0));
      check("pending_mask", 32'(pending_mask), 32'(ep));
      if (!reset) begin
        for (int j = 0; j < 3; j++) if (req_ready[j]) glog.push_back(j);
      end
      @(posedge clk);
      if (!reset) begin
        if (eg >= 0) begin
          m_wr   = 1'b1;
          m_dest = req_dest[eg*4 +: 4];
          m_data = req_data[eg*16 +: 16];
          if (req_r0_en[eg])     m_r0 = req_r0_data[eg*16 +: 16];
          else if (m_dest == 0)  m_r0 = m_data;
          m_ptr = (eg + 1) % 3;
        end else begin
          m_wr = 1'b0;
        end
      end
    end
  end

  initial begin : driver
    int base;
    int first;
    reset = 1'b1;
    req_valid = '0; req_dest = '0; req_data = '0; req_r0_en = '0; req_r0_data = '0;
    #1;
    check("reset_rf_write", 32'(rf_write), 32'd0);
    check("reset_rf_rst_n", 32'(rf_rst_n), 32'd0);
    tick(); tick();
    reset = 1'b0;

    // Single ALU write with R0 preserved
    set_req(0, 1, 4'd5, 16'h1234, 0, 16'h0);
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    check("t1_pending_req", 32'(pending_mask[5]), 32'd1);
    tick();
    clr_all();
    #1;
    check("t1_wr", 32'(rf_write), 32'd1);
    check("t1_dest", 32'(rf_dest), 32'd5);
    check("t1_data", 32'(rf_data), 32'h1234);
    check("t1_r0", 32'(rf_r0_data), 32'h0000);
    check("t1_pending_inflight", 32'(pending_mask[5]), 32'd1);

    // MULDIV side-writes R0, then ALU write carries the shadow
    set_req(2, 1, 4'd3, 16'hAAAA, 1, 16'h0042);
    tick();
    clr_all();
    set_req(0, 1, 4'd7, 16'h5555, 0, 16'h0);
    #1;
    check("t2_r0_side", 32'(rf_r0_data), 32'h0042);
    tick();
    clr_all();
    #1;
    check("t2_dest", 32'(rf_dest), 32'd7);
    check("t2_r0_shadow", 32'(rf_r0_data), 32'h0042);

    // Bring ptr back to 0, then stream with all three valid
    set_req(2, 1, 4'd9, 16'h0909, 0, 16'h0);
    tick();
    clr_all();
    set_req(0, 1, 4'd1, 16'h1001, 0, 16'h0);
    set_req(1, 1, 4'd2, 16'h2002, 0, 16'h0);
    set_req(2, 1, 4'd4, 16'h4004, 0, 16'h0);
    base = glog.size();
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t3_stream_wr", 32'(rf_write), 32'd1);
    end
    clr_all();
    for (int c = 0; c < 6; c++) begin
      if (base + c < glog.size()) check("t3_grant_order", 32'(glog[base + c]), 32'(c % 3));
      else check("t3_grant_missing", 32'(c), 32'hFFFF_FFFF);
    end

    // R0 as destination, then R0 side-write on dest 0, then shadow reuse
    set_req(1, 1, 4'd0, 16'hBEEF, 0, 16'h0);
    tick();
    clr_all();
    #1;
    check("t4_dest0_r0", 32'(rf_r0_data), 32'hBEEF);
    set_req(1, 1, 4'd0, 16'h1111, 1, 16'h2222);
    tick();
    clr_all();
    #1;
    check("t4_r0en_r0", 32'(rf_r0_data), 32'h2222);
    check("t4_r0en_data", 32'(rf_data), 32'h1111);
    set_req(0, 1, 4'd6, 16'h0606, 0, 16'h0);
    tick();
    clr_all();
    #1;
    check("t4_shadow", 32'(rf_r0_data), 32'h2222);

    // Reset right after a transfer
    set_req(0, 1, 4'd8, 16'h0808, 0, 16'h0);
    tick();
    clr_all();
    check("t5_wr_before", 32'(rf_write), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_wr_dropped", 32'(rf_write), 32'd0);
    check("t5_shadow_reset", 32'(rf_r0_data), 32'h0000);
    set_req(0, 1, 4'd10, 16'h0A0A, 0, 16'h0);
    set_req(1, 1, 4'd12, 16'h0C0C, 0, 16'h0);
    #1;
    check("t5_no_grant_in_reset", 32'(req_ready), 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("t5_first_grant", 32'(req_ready), 32'h1);
    tick();
    clr_all();
    #1;
    check("t5_dest", 32'(rf_dest), 32'd10);
    check("t5_r0_after_reset", 32'(rf_r0_data), 32'h0000);

    // Requester 1 held while 0 and 2 alternate; ptr starts at 2
    set_req(1, 1, 4'd11, 16'h0B0B, 0, 16'h0);
    tick();
    clr_all();
    first = -1;
    for (int c = 0; c < 8; c++) begin
      set_req(0, c[0], 4'd12, 16'hC000 + 16'(c), 0, 16'h0);
      set_req(2, ~c[0], 4'd13, 16'hD000 + 16'(c), 0, 16'h0);
      set_req(1, (first < 0), 4'd14, 16'hE0E0, 0, 16'h0);
      #1;
      if (first < 0 && req_ready[1]) first = c;
      tick();
    end
    clr_all();
    check("t6_starve_wait", 32'(first), 32'd2);
    tick(); tick();

    done = 1;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
